// File: rtl/mtx_loader_pkg.sv
// mtx_loader_pkg: shared state encoding, widths and default SDRAM bases for the ioctl loader
package mtx_loader_pkg;
    localparam int ADDR_W  = 23;
    localparam int DATA_W  = 8;
    localparam int ENTRY_W = ADDR_W + DATA_W;
    localparam logic [ADDR_W-1:0] DEF_ROM_BASE   = 23'h000000;
    localparam logic [ADDR_W-1:0] DEF_IMG_BASE   = 23'h100000;
    localparam logic [ADDR_W-1:0] BYTE_COUNT_MAX = 23'h7FFFFF;
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WR_WAIT, S_DRAIN, S_DONE} state_t;
    function automatic logic [ADDR_W-1:0] base_sel(input logic [7:0] idx, input logic [ADDR_W-1:0] rom,
                                                   input logic [ADDR_W-1:0] img);
        return (idx == 8'd0) ? rom : img;
    endfunction
endpackage

// File: rtl/loader_fifo.sv
// loader_fifo: synchronous FIFO of {address, data} SDRAM write entries
module loader_fifo
    import mtx_loader_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_wr,
    input  logic [ENTRY_W-1:0] i_wr_data,
    input  logic               i_rd,
    output logic [ENTRY_W-1:0] o_rd_data,
    output logic               o_full,
    output logic               o_empty
);
    localparam int AW = $clog2(DEPTH);
    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [AW:0]        r_wp;
    logic [AW:0]        r_rp;
    logic               w_rd;
    logic               w_wr;
    // a full FIFO still accepts a push when the head leaves in the same cycle
    assign w_rd      = i_rd && !o_empty;
    assign w_wr      = i_wr && (!o_full || w_rd);
    assign o_empty   = r_wp == r_rp;
    assign o_full    = (r_wp[AW-1:0] == r_rp[AW-1:0]) && (r_wp[AW] != r_rp[AW]);
    assign o_rd_data = r_mem[r_rp[AW-1:0]];
    // storage write
    always_ff @(posedge i_clk) begin
        if (w_wr) r_mem[r_wp[AW-1:0]] <= i_wr_data;
    end
    // read/write pointers with wrap bit
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            r_wp <= r_wp + (AW+1)'(w_wr);
            r_rp <= r_rp + (AW+1)'(w_rd);
        end
    end
endmodule

// File: rtl/ioctl_sdram_loader.sv
// ioctl_sdram_loader: streams ioctl download bytes into SDRAM, passing CPU SRAM traffic through when idle
module ioctl_sdram_loader
    import mtx_loader_pkg::*;
#(
    parameter int                FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] ROM_BASE   = DEF_ROM_BASE,
    parameter logic [ADDR_W-1:0] IMG_BASE   = DEF_IMG_BASE
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [ADDR_W-1:0] ioctl_addr,
    input  logic [7:0]        ioctl_data,
    input  logic [7:0]        ioctl_index,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_din,
    input  logic              cpu_we_n,
    input  logic              cpu_oe_n,
    input  logic              ram_ready,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_din,
    output logic              ram_we,
    output logic              ram_rd,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              overflow,
    output logic [ADDR_W-1:0] byte_count
);
    logic [1:0]         r_rst_sync;
    logic               w_rst_n;
    state_t             r_state;
    state_t             w_next;
    logic               r_dl_prev;
    logic               r_pend;
    logic               r_wait;
    logic               r_overflow;
    logic [ADDR_W-1:0]  r_base;
    logic [ADDR_W-1:0]  r_byte_count;
    logic [ENTRY_W-1:0] w_head;
    logic [ADDR_W-1:0]  w_base;
    logic               w_full;
    logic               w_empty;
    logic               w_idle;
    logic               w_rise;
    logic               w_start;
    logic               w_issue;
    logic               w_push;
    logic               w_commit;

    assign w_rst_n  = r_rst_sync[1];
    assign w_idle   = r_state == S_IDLE;
    assign w_rise   = ioctl_download && !r_dl_prev;
    assign w_start  = w_idle && (w_rise || r_pend);
    assign w_issue  = (r_state == S_LOAD || r_state == S_DRAIN) && !w_empty && ram_ready;
    assign w_commit = r_state == S_WR_WAIT && r_wait && ram_ready;
    assign w_base   = w_start ? base_sel(ioctl_index, ROM_BASE, IMG_BASE) : r_base;
    // bytes are only taken for the download in progress; a re-start seen while draining waits as pending
    assign w_push   = ioctl_download && ioctl_wr &&
                      (w_start || ((r_state == S_LOAD || r_state == S_WR_WAIT) && !r_pend && !w_rise));
    assign overflow   = r_overflow;
    assign byte_count = r_byte_count;

    loader_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk     (clk_sys),
        .i_rst_n   (w_rst_n),
        .i_wr      (w_push),
        .i_wr_data ({w_base + ioctl_addr, ioctl_data}),
        .i_rd      (w_issue),
        .o_rd_data (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    // reset asserts immediately but is released two clocks later, in step with clk_sys
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) r_rst_sync <= 2'b00;
        else          r_rst_sync <= {r_rst_sync[0], 1'b1};
    end

    // state register
    always_ff @(posedge clk_sys or negedge w_rst_n) begin
        if (!w_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    w_next = w_start ? S_LOAD : S_IDLE;
            S_LOAD:    w_next = w_issue ? S_WR_WAIT : ((!ioctl_download || r_pend) ? S_DRAIN : S_LOAD);
            S_WR_WAIT: w_next = !w_commit ? S_WR_WAIT :
                                ((ioctl_download && !r_pend && !w_rise) ? S_LOAD : S_DRAIN);
            S_DRAIN:   w_next = w_issue ? S_WR_WAIT : ((w_empty && ram_ready) ? S_DONE : S_DRAIN);
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // outputs: CPU pass-through when idle, loader head entry otherwise
    always_comb begin
        ram_we    = w_idle ? ~cpu_we_n : w_issue;
        ram_rd    = w_idle & ~cpu_oe_n;
        ram_addr  = w_idle ? cpu_addr : w_head[ENTRY_W-1:DATA_W];
        ram_din   = w_idle ? cpu_din : w_head[DATA_W-1:0];
        cpu_hold  = !w_idle;
        load_done = r_state == S_DONE;
    end

    // download edge tracking, base latch, commit counter and overrun flag;
    // r_dl_prev resets high so a download still active across reset is not restarted
    always_ff @(posedge clk_sys or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_dl_prev    <= 1'b1;
            r_pend       <= 1'b0;
            r_wait       <= 1'b0;
            r_overflow   <= 1'b0;
            r_base       <= '0;
            r_byte_count <= '0;
        end else begin
            r_dl_prev <= ioctl_download;
            r_pend    <= w_start ? 1'b0 : (r_pend || (w_rise && !w_idle));
            r_wait    <= r_state == S_WR_WAIT;
            if (w_start) begin
                r_base       <= w_base;
                r_byte_count <= '0;
                r_overflow   <= 1'b0;
            end else begin
                if (w_commit && r_byte_count != BYTE_COUNT_MAX) r_byte_count <= r_byte_count + 1'b1;
                if (w_push && w_full && !w_issue) r_overflow <= 1'b1;
            end
        end
    end
endmodule
